// File: rtl/processor_defines.sv
// Shared processor definitions: store-size encodings, store buffer FSM states
// and the store queue entry layout.
package processor_defines;

   localparam logic [2:0] STR_NOP = 3'b000;
   localparam logic [2:0] SB      = 3'b001;
   localparam logic [2:0] SH      = 3'b010;
   localparam logic [2:0] SW      = 3'b011;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } sb_state_t;

   typedef struct packed {
      logic [29:0] word_addr;
      logic [3:0]  be;
      logic [31:0] data;
   } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store queue. Entry storage is plain registers without reset; only
// pointers and the occupancy count are cleared, so reset discards all entries.
module store_fifo
   import processor_defines::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  store_entry_t             wr_entry,
   output store_entry_t             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   store_entry_t entries [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic do_push;
   logic do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = entries[rd_ptr];

   // Write the incoming entry at the tail; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         entries[wr_ptr] <= wr_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; a push and pop
   // in the same cycle leave the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer controller: formats stores into byte lanes, rejects misaligned
// accesses, queues them and issues one memory write per grant.
module store_buffer_ctrl
   import processor_defines::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [2:0]  store_control,
   input  logic        fence_req,
   output logic        fence_done,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        misalign_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   sb_state_t       state;
   store_entry_t    head;
   store_entry_t    new_entry;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_after_pop;
   logic            accept;
   logic            op_valid;
   logic            misaligned;
   logic            enqueue;
   logic            pop;
   logic [3:0]      fmt_be;
   logic [31:0]     fmt_data;

   assign st_ready   = !full && !fence_req;
   assign accept     = st_valid && st_ready;
   assign enqueue    = accept && op_valid && !misaligned;
   assign pop        = (state == ISSUE) && mem_gnt && !empty;
   assign fence_done = fence_req && (count == '0) && (state == IDLE);

   assign new_entry.word_addr = st_addr[31:2];
   assign new_entry.be        = fmt_be;
   assign new_entry.data      = fmt_data;

   // The head is held in registers, so the write stays stable until granted.
   assign mem_addr  = mem_req ? {head.word_addr, 2'b00} : '0;
   assign mem_wdata = mem_req ? head.data : '0;
   assign mem_be    = mem_req ? head.be : '0;

   // Decode the store size into byte enables, replicated lane data and an
   // alignment verdict; NOP and unknown codes are simply consumed.
   always_comb begin
      op_valid   = 1'b0;
      misaligned = 1'b0;
      fmt_be     = 4'b0000;
      fmt_data   = st_data;
      case (store_control)
         SB: begin
            op_valid = 1'b1;
            fmt_be   = 4'b0001 << st_addr[1:0];
            fmt_data = {4{st_data[7:0]}};
         end
         SH: begin
            op_valid   = 1'b1;
            misaligned = st_addr[0];
            fmt_be     = st_addr[1] ? 4'b1100 : 4'b0011;
            fmt_data   = {2{st_data[15:0]}};
         end
         SW: begin
            op_valid   = 1'b1;
            misaligned = |st_addr[1:0];
            fmt_be     = 4'b1111;
            fmt_data   = st_data;
         end
         default: begin
            op_valid = 1'b0;
         end
      endcase
   end

   // Occupancy after the current head retires, including a same-edge push.
   always_comb begin
      count_after_pop = count - CW'(1) + CW'(enqueue);
   end

   // Two-state issue FSM; mem_req mirrors the ISSUE state as a register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         mem_req      <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= accept && op_valid && misaligned;
         case (state)
            IDLE: begin
               if (enqueue || (count != '0)) begin
                  state   <= ISSUE;
                  mem_req <= 1'b1;
               end
            end
            ISSUE: begin
               if (mem_gnt && (count_after_pop == '0)) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   store_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (enqueue),
      .pop      (pop),
      .wr_entry (new_entry),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl using a queue of expected memory
// writes that is filled on acceptance and drained as grants are observed.
module tb_store_buffer_ctrl;
   import processor_defines::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [2:0]  store_control = STR_NOP;
   logic        fence_req = 1'b0;
   logic        fence_done;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        misalign_err;

   int checkCount = 0;
   int errorCount = 0;
   int writesSeen = 0;
   int writesBefore;
   store_entry_t sb[$];
   logic [2:0] ctrlTable [5] = '{SB, SH, SW, STR_NOP, 3'b111};

   store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .st_valid      (st_valid),
      .st_ready      (st_ready),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .store_control (store_control),
      .fence_req     (fence_req),
      .fence_done    (fence_done),
      .mem_req       (mem_req),
      .mem_gnt       (mem_gnt),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .misalign_err  (misalign_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count one comparison and report it when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic modelMisaligned(input logic [2:0] ctrl, input logic [31:0] addr);
      return ((ctrl == SH) && addr[0]) || ((ctrl == SW) && (addr[1:0] != 2'b00));
   endfunction

   function automatic logic modelEnqueues(input logic [2:0] ctrl, input logic [31:0] addr);
      return ((ctrl == SB) || (ctrl == SH) || (ctrl == SW)) && !modelMisaligned(ctrl, addr);
   endfunction

   function automatic store_entry_t modelEntry(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
      store_entry_t e;
      e.word_addr = addr[31:2];
      e.be = 4'b1111;
      e.data = data;
      if (ctrl == SB) begin
         case (addr[1:0])
            2'd0: e.be = 4'b0001;
            2'd1: e.be = 4'b0010;
            2'd2: e.be = 4'b0100;
            default: e.be = 4'b1000;
         endcase
         e.data = {data[7:0], data[7:0], data[7:0], data[7:0]};
      end else if (ctrl == SH) begin
         e.be = addr[1] ? 4'b1100 : 4'b0011;
         e.data = {data[15:0], data[15:0]};
      end
      return e;
   endfunction

   // Compare the presented write with the oldest expected entry every cycle;
   // retire it from the queue when the grant will be taken at the next edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_req) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedReq", 32'd1, 32'd0);
            end else begin
               checkOutput("memAddr", mem_addr, {sb[0].word_addr, 2'b00});
               checkOutput("memBe", {28'd0, mem_be}, {28'd0, sb[0].be});
               checkOutput("memWdata", mem_wdata, sb[0].data);
               if (mem_gnt) begin
                  void'(sb.pop_front());
                  writesSeen++;
               end
            end
         end else begin
            checkOutput("idleOutputs", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
         end
      end
   end

   // Advance one cycle and check request and fence status against the model.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      checkOutput("memReq", {31'd0, mem_req}, {31'd0, sb.size() != 0});
      checkOutput("fenceDone", {31'd0, fence_done}, {31'd0, fence_req && (sb.size() == 0)});
   endtask

   // Present one store for one cycle, predict acceptance and record the write.
   task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
      logic expReady;
      st_valid = 1'b1;
      store_control = ctrl;
      st_addr = addr;
      st_data = data;
      expReady = (sb.size() < DEPTH) && !fence_req;
      @(negedge clk);
      checkOutput("stReady", {31'd0, st_ready}, {31'd0, expReady});
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      store_control = STR_NOP;
      if (expReady && modelEnqueues(ctrl, addr)) begin
         sb.push_back(modelEntry(ctrl, addr, data));
      end
      checkOutput("misalignErr", {31'd0, misalign_err}, {31'd0, expReady && modelMisaligned(ctrl, addr)});
      checkOutput("memReq", {31'd0, mem_req}, {31'd0, sb.size() != 0});
   endtask

   // Grant continuously until the model queue is empty or the budget expires.
   task automatic drain(input int budget);
      mem_gnt = 1'b1;
      for (int i = 0; i < budget && sb.size() != 0; i++) begin
         stepCycle();
      end
      checkOutput("drainDone", sb.size(), 32'd0);
      mem_gnt = 1'b0;
   endtask

   // Directed scenarios followed by a short randomized run.
   initial begin
      #2;
      checkOutput("resetMemReq", {31'd0, mem_req}, 32'd0);
      checkOutput("resetMemAddr", mem_addr, 32'd0);
      checkOutput("resetMisalign", {31'd0, misalign_err}, 32'd0);
      checkOutput("resetReady", {31'd0, st_ready}, 32'd1);
      checkOutput("resetFenceDone", {31'd0, fence_done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Byte store to the top lane with the grant held high.
      mem_gnt = 1'b1;
      applyStimulus(SB, 32'h0000_1003, 32'h0000_00AB);
      checkOutput("sbAddr", mem_addr, 32'h0000_1000);
      checkOutput("sbBe", {28'd0, mem_be}, 32'h8);
      checkOutput("sbWdata", mem_wdata, 32'hABAB_ABAB);
      stepCycle();
      checkOutput("sbWrites", writesSeen, 32'd1);

      // Misaligned halfword is consumed and flagged for one cycle.
      applyStimulus(SH, 32'h0000_2001, 32'h0000_1234);
      stepCycle();
      checkOutput("misalignPulse", {31'd0, misalign_err}, 32'd0);
      checkOutput("readyAfterMisalign", {31'd0, st_ready}, 32'd1);

      // Fill the queue with the grant low, then retire it with no bubble.
      mem_gnt = 1'b0;
      writesBefore = writesSeen;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(SW, 32'h0000_3000 + 32'(4 * i), 32'h1111_0000 + 32'(i));
      end
      mem_gnt = 1'b1;
      repeat (4) stepCycle();
      checkOutput("fullDrainWrites", writesSeen - writesBefore, 32'd4);
      mem_gnt = 1'b0;

      // Full queue with a grant and a new store in the same cycle.
      writesBefore = writesSeen;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(SW, 32'h0000_4000 + 32'(4 * i), 32'h2222_0000 + 32'(i));
      end
      mem_gnt = 1'b1;
      applyStimulus(SW, 32'h0000_4100, 32'hDEAD_BEEF);
      checkOutput("readyAfterFullPop", {31'd0, st_ready}, 32'd1);
      drain(10);
      checkOutput("fullPopWrites", writesSeen - writesBefore, 32'd4);

      // Fence with two queued stores drains them and then reports done.
      applyStimulus(SH, 32'h0000_5002, 32'h0000_BEEF);
      applyStimulus(SB, 32'h0000_5005, 32'h0000_0077);
      fence_req = 1'b1;
      mem_gnt = 1'b1;
      applyStimulus(SW, 32'h0000_5100, 32'h1234_5678);
      stepCycle();
      checkOutput("fenceReady", {31'd0, st_ready}, 32'd0);
      fence_req = 1'b0;
      mem_gnt = 1'b0;
      stepCycle();

      // Reset in the middle of an outstanding request discards the queue.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(SW, 32'h0000_6000 + 32'(4 * i), 32'h3333_0000 + 32'(i));
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncResetReq", {31'd0, mem_req}, 32'd0);
      checkOutput("asyncResetAddr", mem_addr, 32'd0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_gnt = 1'b1;
      writesBefore = writesSeen;
      repeat (3) stepCycle();
      checkOutput("writesAfterReset", writesSeen - writesBefore, 32'd0);
      checkOutput("readyAfterReset", {31'd0, st_ready}, 32'd1);

      // Random mix of store sizes, addresses and grant patterns.
      for (int i = 0; i < 60; i++) begin
         mem_gnt = 1'($urandom_range(0, 1));
         applyStimulus(ctrlTable[$urandom_range(0, 4)], $urandom, $urandom);
      end
      drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
